// File: rtl/dp_ram_ctrl_pkg.sv
// Shared types and constants for the dual-port RAM controller.
//   ctrl_state_e : controller sequencing states (reset hold, clear sweep, run)
//   NUM_WR_REQ   : number of write requesters sharing the RAM write port
package dp_ram_ctrl_pkg;

   localparam int unsigned NUM_WR_REQ = 2;

   typedef enum logic [1:0] {
      RST  = 2'd0,
      INIT = 2'd1,
      RUN  = 2'd2
   } ctrl_state_e;

   // Bitwise masked merge: bits set in mask take new_word, others keep old_word.
   function automatic logic [63:0] masked_merge(input logic [63:0] old_word,
                                                input logic [63:0] new_word,
                                                input logic [63:0] mask);
      return (old_word & ~mask) | (new_word & mask);
   endfunction

endpackage

// File: rtl/dp_ram_ctrl_arb.sv
// Two-way round-robin arbiter for the RAM write port.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   valid      : request per requester
//   advance    : arbitration enabled this cycle (grants forced low otherwise)
//   grant      : one-hot grant, combinational from valid and last_grant
// last_grant resets to 1 so the first contended cycle favours requester 0.
module rr_arbiter_2
   import dp_ram_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_WR_REQ-1:0] valid,
   input  logic                  advance,
   output logic [NUM_WR_REQ-1:0] grant
);

   logic last_grant;

   // Single requester wins outright; on contention the one not served last wins.
   always_comb begin
      grant = '0;
      if (advance) begin
         case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = '0;
         endcase
      end
   end

   // Remember the index of the most recent grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
      end else if (|grant) begin
         last_grant <= grant[1];
      end
   end

endmodule

// File: rtl/dp_ram_ctrl.sv
// Sequencing and arbitration controller in front of one dual-port RAM.
// After reset it sweeps every entry to INIT_VALUE through the write port,
// then shares the write port between two requesters (round robin) and
// serves one reader with a fixed one-cycle response.
// Ports:
//   CLK, rst_n             : clock, asynchronous active-low reset
//   clear_req              : start a new clear sweep (honoured in RUN only)
//   init_done              : high while in RUN
//   wr_valid/wr_ready      : per-requester write request / grant
//   wr_addr*/wr_data*/wr_mask* : per-requester write payload (mask 1 = write bit)
//   rd_valid/rd_ready/rd_addr  : read request / accept / address
//   rd_rvalid/rd_rdata     : read response, one cycle after accept
//   ram_cea/ram_aa/ram_qa  : RAM read port
//   ram_ceb/ram_ab/ram_db/ram_bwb : RAM write port
module dp_ram_ctrl
   import dp_ram_ctrl_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = 8,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                  CLK,
   input  logic                  rst_n,
   input  logic                  clear_req,
   output logic                  init_done,
   input  logic [NUM_WR_REQ-1:0] wr_valid,
   output logic [NUM_WR_REQ-1:0] wr_ready,
   input  logic [ADDR_WIDTH-1:0] wr_addr0,
   input  logic [ADDR_WIDTH-1:0] wr_addr1,
   input  logic [DATA_WIDTH-1:0] wr_data0,
   input  logic [DATA_WIDTH-1:0] wr_data1,
   input  logic [DATA_WIDTH-1:0] wr_mask0,
   input  logic [DATA_WIDTH-1:0] wr_mask1,
   input  logic                  rd_valid,
   output logic                  rd_ready,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_rvalid,
   output logic [DATA_WIDTH-1:0] rd_rdata,
   output logic                  ram_cea,
   output logic [ADDR_WIDTH-1:0] ram_aa,
   output logic                  ram_ceb,
   output logic [ADDR_WIDTH-1:0] ram_ab,
   output logic [DATA_WIDTH-1:0] ram_db,
   output logic [DATA_WIDTH-1:0] ram_bwb,
   input  logic [DATA_WIDTH-1:0] ram_qa
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};

   ctrl_state_e           state;
   logic [ADDR_WIDTH-1:0] sweep_cnt;
   logic                  in_init;
   logic                  in_run;
   logic [NUM_WR_REQ-1:0] grant;

   assign in_init = (state == INIT);
   assign in_run  = (state == RUN);

   rr_arbiter_2 u_arb (
      .clk     (CLK),
      .rst_n   (rst_n),
      .valid   (wr_valid),
      .advance (in_run),
      .grant   (grant)
   );

   // Controller state, sweep counter and read-valid pipeline.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RST;
         sweep_cnt <= '0;
         rd_rvalid <= 1'b0;
      end else begin
         rd_rvalid <= rd_valid && in_run;
         case (state)
            RST: begin
               state     <= INIT;
               sweep_cnt <= '0;
            end
            INIT: begin
               // Counter wraps to 0 naturally on the last address.
               sweep_cnt <= sweep_cnt + ADDR_WIDTH'(1);
               if (sweep_cnt == ADDR_LAST) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (clear_req) begin
                  state     <= INIT;
                  sweep_cnt <= '0;
               end
            end
            default: begin
               state     <= RST;
               sweep_cnt <= '0;
            end
         endcase
      end
   end

   assign init_done = in_run;
   assign rd_ready  = in_run;
   assign wr_ready  = grant;
   assign rd_rdata  = rd_rvalid ? ram_qa : '0;

   // Write port: sweep owns it during INIT, granted requester in RUN.
   always_comb begin
      ram_ceb = 1'b0;
      ram_ab  = '0;
      ram_db  = '0;
      ram_bwb = '0;
      if (in_init) begin
         ram_ceb = 1'b1;
         ram_ab  = sweep_cnt;
         ram_db  = INIT_VALUE;
         ram_bwb = '1;
      end else if (grant[0]) begin
         ram_ceb = 1'b1;
         ram_ab  = wr_addr0;
         ram_db  = wr_data0;
         ram_bwb = wr_mask0;
      end else if (grant[1]) begin
         ram_ceb = 1'b1;
         ram_ab  = wr_addr1;
         ram_db  = wr_data1;
         ram_bwb = wr_mask1;
      end
   end

   // Read port: every request is accepted in RUN; address zeroed when idle.
   always_comb begin
      ram_cea = in_run && rd_valid;
      ram_aa  = ram_cea ? rd_addr : '0;
   end

endmodule

// File: tb/tb_dp_ram_ctrl.sv
// Directed self-checking bench for dp_ram_ctrl with a behavioural RAM and a
// read-data scoreboard.
module tb_dp_ram_ctrl;

   localparam int unsigned AW    = 4;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 16;
   localparam logic [DW-1:0] INIT = 32'hDEAD_BEEF;
   localparam logic [DW-1:0] ONES = 32'hFFFF_FFFF;

   logic          CLK;
   logic          rst_n;
   logic          clear_req;
   logic          init_done;
   logic [1:0]    wr_valid;
   logic [1:0]    wr_ready;
   logic [AW-1:0] wr_addr0, wr_addr1;
   logic [DW-1:0] wr_data0, wr_data1;
   logic [DW-1:0] wr_mask0, wr_mask1;
   logic          rd_valid;
   logic          rd_ready;
   logic [AW-1:0] rd_addr;
   logic          rd_rvalid;
   logic [DW-1:0] rd_rdata;
   logic          ram_cea;
   logic [AW-1:0] ram_aa;
   logic          ram_ceb;
   logic [AW-1:0] ram_ab;
   logic [DW-1:0] ram_db;
   logic [DW-1:0] ram_bwb;
   logic [DW-1:0] ram_qa;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW-1:0] rd_q [$];

   dp_ram_ctrl #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .INIT_VALUE (INIT)
   ) dut (
      .CLK       (CLK),
      .rst_n     (rst_n),
      .clear_req (clear_req),
      .init_done (init_done),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_addr0  (wr_addr0),
      .wr_addr1  (wr_addr1),
      .wr_data0  (wr_data0),
      .wr_data1  (wr_data1),
      .wr_mask0  (wr_mask0),
      .wr_mask1  (wr_mask1),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_addr   (rd_addr),
      .rd_rvalid (rd_rvalid),
      .rd_rdata  (rd_rdata),
      .ram_cea   (ram_cea),
      .ram_aa    (ram_aa),
      .ram_ceb   (ram_ceb),
      .ram_ab    (ram_ab),
      .ram_db    (ram_db),
      .ram_bwb   (ram_bwb),
      .ram_qa    (ram_qa)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Behavioural dual-port RAM with write-to-read bypass on masked bits.
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] qa_r;
   assign ram_qa = qa_r;

   always @(posedge CLK) begin
      if (ram_ceb) mem[ram_ab] <= (mem[ram_ab] & ~ram_bwb) | (ram_db & ram_bwb);
      if (ram_cea) begin
         if (ram_ceb && ram_ab == ram_aa)
            qa_r <= (mem[ram_aa] & ~ram_bwb) | (ram_db & ram_bwb);
         else
            qa_r <= mem[ram_aa];
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] o,
                                           input logic [DW-1:0] d,
                                           input logic [DW-1:0] m);
      return (o & ~m) | (d & m);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; check the read response against the scoreboard.
   task automatic tick();
      @(posedge CLK);
      #1;
      if (rd_q.size() > 0) begin
         chk("rd_rvalid", 64'(rd_rvalid), 64'd1);
         chk("rd_rdata", 64'(rd_rdata), 64'(rd_q.pop_front()));
      end else begin
         chk("rd_rvalid_idle", 64'(rd_rvalid), 64'd0);
      end
      @(negedge CLK);
   endtask

   task automatic sweep_check(input int i);
      chk("sweep_ceb", 64'(ram_ceb), 64'd1);
      chk("sweep_ab", 64'(ram_ab), 64'(i));
      chk("sweep_db", 64'(ram_db), 64'(INIT));
      chk("sweep_bwb", 64'(ram_bwb), 64'(ONES));
      chk("sweep_wr_ready", 64'(wr_ready), 64'd0);
      chk("sweep_rd_ready", 64'(rd_ready), 64'd0);
      chk("sweep_cea", 64'(ram_cea), 64'd0);
      chk("sweep_init_done", 64'(init_done), 64'd0);
   endtask

   task automatic chk_wr(input string tag, input logic [1:0] g, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] m);
      chk({tag, "_ready"}, 64'(wr_ready), 64'(g));
      chk({tag, "_ceb"}, 64'(ram_ceb), 64'd1);
      chk({tag, "_ab"}, 64'(ram_ab), 64'(a));
      chk({tag, "_db"}, 64'(ram_db), 64'(d));
      chk({tag, "_bwb"}, 64'(ram_bwb), 64'(m));
      ref_mem[a] = merge(ref_mem[a], d, m);
   endtask

   task automatic full_sweep();
      for (int i = 0; i < int'(DEPTH); i++) begin
         #1;
         sweep_check(i);
         if (i == int'(DEPTH) - 1) begin
            wr_valid = 2'b00;
            rd_valid = 1'b0;
         end
         tick();
      end
      for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = INIT;
   endtask

   initial begin
      rst_n = 1'b0; clear_req = 1'b0; wr_valid = 2'b00; rd_valid = 1'b0;
      wr_addr0 = '0; wr_addr1 = '0; wr_data0 = '0; wr_data1 = '0;
      wr_mask0 = '0; wr_mask1 = '0; rd_addr = '0;
      repeat (3) @(negedge CLK);
      #1;
      chk("rst_init_done", 64'(init_done), 64'd0);
      chk("rst_rd_rvalid", 64'(rd_rvalid), 64'd0);
      chk("rst_ceb", 64'(ram_ceb), 64'd0);
      chk("rst_cea", 64'(ram_cea), 64'd0);
      chk("rst_wr_ready", 64'(wr_ready), 64'd0);
      chk("rst_rd_ready", 64'(rd_ready), 64'd0);
      chk("rst_rd_rdata", 64'(rd_rdata), 64'd0);
      @(negedge CLK);

      // Release reset with requesters and reader pushing during the sweep.
      wr_valid = 2'b11; rd_valid = 1'b1;
      wr_addr0 = 4'd2; wr_addr1 = 4'd9; wr_data0 = 32'h1111_1111; wr_data1 = 32'h2222_2222;
      wr_mask0 = ONES; wr_mask1 = ONES; rd_addr = 4'd1;
      rst_n = 1'b1;
      #1;
      chk("rstst_ceb", 64'(ram_ceb), 64'd0);
      chk("rstst_wr_ready", 64'(wr_ready), 64'd0);
      tick();
      full_sweep();
      #1;
      chk("init_done_up", 64'(init_done), 64'd1);
      tick();

      // Read back every address after the power-on sweep.
      for (int i = 0; i < int'(DEPTH); i++) begin
         rd_valid = 1'b1; rd_addr = AW'(i);
         #1;
         chk("rd_ready", 64'(rd_ready), 64'd1);
         chk("rd_cea", 64'(ram_cea), 64'd1);
         chk("rd_aa", 64'(ram_aa), 64'(i));
         rd_q.push_back(ref_mem[i]);
         tick();
      end
      rd_valid = 1'b0;

      // Contention: grants alternate 0,1,0,1.
      wr_valid = 2'b11;
      wr_addr0 = 4'd8; wr_data0 = 32'hA0A0_A0A0; wr_mask0 = ONES;
      wr_addr1 = 4'd9; wr_data1 = 32'hB1B1_B1B1; wr_mask1 = ONES;
      for (int k = 0; k < 4; k++) begin
         #1;
         if (k % 2 == 0) chk_wr("alt0", 2'b01, 4'd8, 32'hA0A0_A0A0, ONES);
         else            chk_wr("alt1", 2'b10, 4'd9, 32'hB1B1_B1B1, ONES);
         tick();
      end

      // Lone requester 1 wins even though it was granted last.
      wr_valid = 2'b10; wr_addr1 = 4'd10; wr_data1 = 32'h1234_5678; wr_mask1 = 32'h0000_FFFF;
      #1;
      chk_wr("solo1", 2'b10, 4'd10, 32'h1234_5678, 32'h0000_FFFF);
      tick();

      // Same-address write and read in one cycle.
      wr_valid = 2'b01; wr_addr0 = 4'd3; wr_data0 = 32'h0000_00FF; wr_mask0 = 32'h0000_000F;
      rd_valid = 1'b1; rd_addr = 4'd3;
      #1;
      rd_q.push_back(merge(ref_mem[3], 32'h0000_00FF, 32'h0000_000F));
      chk_wr("coll", 2'b01, 4'd3, 32'h0000_00FF, 32'h0000_000F);
      tick();
      wr_valid = 2'b00;

      for (int a = 8; a <= 10; a++) begin
         rd_addr = AW'(a);
         #1;
         rd_q.push_back(ref_mem[a]);
         tick();
      end
      rd_valid = 1'b0;

      // Idle cycle: unused ports drive zeros.
      #1;
      chk("idle_ceb", 64'(ram_ceb), 64'd0);
      chk("idle_ab", 64'(ram_ab), 64'd0);
      chk("idle_db", 64'(ram_db), 64'd0);
      chk("idle_bwb", 64'(ram_bwb), 64'd0);
      chk("idle_cea", 64'(ram_cea), 64'd0);
      chk("idle_aa", 64'(ram_aa), 64'd0);
      chk("idle_wr_ready", 64'(wr_ready), 64'd0);
      tick();

      // Clear request alongside a write and a read of the same address.
      clear_req = 1'b1;
      wr_valid = 2'b10; wr_addr1 = 4'd5; wr_data1 = 32'h1234_5678; wr_mask1 = ONES;
      rd_valid = 1'b1; rd_addr = 4'd5;
      #1;
      rd_q.push_back(merge(ref_mem[5], 32'h1234_5678, ONES));
      chk_wr("clr_wr", 2'b10, 4'd5, 32'h1234_5678, ONES);
      tick();
      clear_req = 1'b0; wr_valid = 2'b11; rd_valid = 1'b1;
      full_sweep();
      rd_valid = 1'b1; rd_addr = 4'd5;
      #1;
      chk("clr_init_done", 64'(init_done), 64'd1);
      rd_q.push_back(ref_mem[5]);
      tick();
      rd_valid = 1'b0;

      // Reset asserted at sweep address 7.
      clear_req = 1'b1;
      #1;
      tick();
      clear_req = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         sweep_check(i);
         if (i < 7) tick();
      end
      rst_n = 1'b0;
      #1;
      chk("mid_rst_init_done", 64'(init_done), 64'd0);
      chk("mid_rst_ceb", 64'(ram_ceb), 64'd0);
      chk("mid_rst_ab", 64'(ram_ab), 64'd0);
      chk("mid_rst_db", 64'(ram_db), 64'd0);
      chk("mid_rst_bwb", 64'(ram_bwb), 64'd0);
      chk("mid_rst_rvalid", 64'(rd_rvalid), 64'd0);
      chk("mid_rst_rd_ready", 64'(rd_ready), 64'd0);
      @(negedge CLK);
      rst_n = 1'b1;
      #1;
      chk("rerst_ceb", 64'(ram_ceb), 64'd0);
      tick();
      full_sweep();
      rd_valid = 1'b1; rd_addr = 4'd10;
      #1;
      chk("final_init_done", 64'(init_done), 64'd1);
      rd_q.push_back(ref_mem[10]);
      tick();
      rd_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dp_ram_ctrl.md
# dp_ram_ctrl

Sequencing and arbitration controller placed directly in front of one `dp_ram_asic` instance. After reset it clears every RAM entry to `INIT_VALUE` through the write port. It then shares that write port between two write requesters using round-robin arbitration, and serves one read requester on the read port with a fixed one-cycle response. Read/write collision bypass stays inside the RAM wrapper; this block never stalls on address conflicts.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: RAM address width; depth is 2**ADDR_WIDTH.
- `DATA_WIDTH`, 32: RAM word width.
- `INIT_VALUE`, '0: word written to every entry during a clear sweep.

Ports:
- `CLK`  in  1  single clock for the controller and both RAM ports.
- `rst_n`  in  1  asynchronous active-low reset.
- `clear_req`  in  1  pulse while in RUN starts a new clear sweep.
- `init_done`  out  1  1 while in RUN.
- `wr_valid[1:0]`  in  2  write request per requester.
- `wr_ready[1:0]`  out  2  grant per requester; at most one bit set.
- `wr_addr0`, `wr_addr1`  in  ADDR_WIDTH  write address per requester.
- `wr_data0`, `wr_data1`  in  DATA_WIDTH  write data per requester.
- `wr_mask0`, `wr_mask1`  in  DATA_WIDTH  bit-write enable per requester; 1 writes the bit.
- `rd_valid`  in  1  read request.
- `rd_ready`  out  1  read accepted.
- `rd_addr`  in  ADDR_WIDTH  read address.
- `rd_rvalid`  out  1  read data valid.
- `rd_rdata`  out  DATA_WIDTH  read data.
- `ram_cea`, `ram_aa`  out  1 / ADDR_WIDTH  RAM read enable and read address.
- `ram_ceb`, `ram_ab`, `ram_db`, `ram_bwb`  out  1 / ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH  RAM write enable, address, data and bit mask.
- `ram_qa`  in  DATA_WIDTH  RAM read data, valid the cycle after `ram_cea`.

## Operation
- FSM states are RST, INIT and RUN. The asynchronous reset value is RST, with the sweep counter at 0, `last_grant`=1 and `rd_rvalid`=0.
- RST to INIT: unconditional, one cycle after reset deassertion. No RAM access is made in RST.
- INIT:
  - Each cycle: `ram_ceb`=1, `ram_ab`=counter, `ram_db`=INIT_VALUE, `ram_bwb`=all ones; the counter then increments.
  - When the counter reaches 2**ADDR_WIDTH-1, that write is issued, the counter wraps to 0 and the FSM goes to RUN.
  - `wr_ready`=0, `rd_ready`=0 and `clear_req` is ignored throughout.
- RUN, write arbitration (combinational):
  - If exactly one `wr_valid` bit is set, that requester is granted.
  - If both are set, the requester other than `last_grant` is granted.
  - On each grant, `last_grant` updates to the granted index.
- RUN, write port: `ram_ceb` = any grant. `ram_ab`, `ram_db` and `ram_bwb` come from the granted requester's address, data and mask.
- RUN, read port: `rd_ready`=1; `ram_cea`=`rd_valid`; `ram_aa`=`rd_addr`.
- `rd_rvalid` is registered: it is 1 the cycle after an accepted read, and `rd_rdata`=`ram_qa` in that cycle.
- Read and write to the same address in the same cycle: both are issued. The RAM wrapper returns the newly written bits on the masked positions.
- `clear_req` in RUN:
  - Requests and reads presented that same cycle are still served.
  - Next state is INIT with the counter at 0.
  - `rd_rvalid` for a read accepted in that cycle is still produced.
- Reset asserted mid-sweep or mid-read: everything returns to RST immediately and `rd_rvalid` clears. Any partial sweep is redone from address 0.
- When RAM ports are unused: `ram_cea`/`ram_ceb` are 0 and the address, data and mask outputs are 0.

## Timing
- A clear sweep takes 2**ADDR_WIDTH cycles. `init_done` rises 2**ADDR_WIDTH+1 cycles after reset release.
- Write latency: the grant and `ram_ceb` occur in the same cycle as `wr_valid`. Throughput is one write per cycle across both requesters.
- Read latency: exactly one cycle, with one read per cycle and no backpressure on `rd_rvalid`.
- Registered outputs: `init_done`, `rd_rvalid` and `last_grant`. All other outputs are combinational from inputs and state.

## Structure
- Package `dp_ram_ctrl_pkg` holds the `ctrl_state_e` enum (RST, INIT, RUN) and the `NUM_WR_REQ`=2 constant.
- One natural sub-module, `rr_arbiter_2`: two-way round-robin arbiter taking `valid[1:0]` and `advance`, producing a one-hot `grant[1:0]` and holding the `last_grant` register.
- Top level contains the FSM, sweep counter, RAM port muxing and the read valid pipeline.

## Test plan
- ADDR_WIDTH=4, INIT_VALUE=32'hDEAD_BEEF, release reset: exactly 16 writes to addresses 0..15, all with mask all ones; `init_done`=1 at cycle 17; reading each address returns DEADBEEF.
- Both requesters hold `wr_valid` for 4 cycles after init: grants alternate 0,1,0,1; RAM sees the four writes in that order.
- Write addr 3, data 0000_00FF, mask 0000_000F, while reading addr 3 in the same cycle: the next cycle `rd_rvalid`=1 and `rd_rdata`=DEADBEEF.
- Assert `clear_req` alongside a write of 1234_5678 to addr 5 (mask all ones): the write is issued, the sweep restarts at 0, addr 5 later reads INIT_VALUE, and ready stays 0 for 16 cycles.
- Assert reset at sweep address 7: all outputs go to 0 immediately; after release the sweep restarts at address 0.
- During INIT, hold `wr_valid`=2'b11 and `rd_valid`=1: ready stays 0, and no requester access reaches the RAM until `init_done`.
